// File: rtl/operand_assembler.sv
// operand_assembler
// Collects the 1-3 word A/B stream from the operand register stage into
// full-width operands for the GF(2^m) arithmetic units. The assembled operand
// and its op code are held until the consumer accepts them (op_valid/op_ready).
//
// Build option: define OPERAND_ASSEMBLER_MASK_EN to zero every operand bit at
// or above the latched field degree m when the operand is completed.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for the first word of an operand
// COLLECT | first word taken, gathering the remaining words
// HOLD    | operand complete, op_valid high until op_ready
module operand_assembler #(
    parameter int Data     = 256,
    parameter int MaxWords = 3,
    parameter int Mul      = 1,
    parameter int Sqr      = 2,
    parameter int Inv      = 3,
    parameter int Xor      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [Data-1:0]          word_a,
    input  logic [Data-1:0]          word_b,
    input  logic                     word_valid,
    output logic                     word_ready,
    input  logic [2:0]               command,
    input  logic                     flush,
    input  logic [9:0]               Polynomial_Length,
    output logic [Data*MaxWords-1:0] op_a,
    output logic [Data*MaxWords-1:0] op_b,
    output logic [2:0]               op_cmd,
    output logic                     op_valid,
    input  logic                     op_ready,
    output logic                     err
);

    localparam int W  = Data * MaxWords;
    localparam int IW = (MaxWords > 1) ? $clog2(MaxWords) : 1;
    localparam int CW = $clog2(MaxWords + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;

    localparam logic [2:0] CMD_MUL = 3'(Mul);
    localparam logic [2:0] CMD_SQR = 3'(Sqr);
    localparam logic [2:0] CMD_INV = 3'(Inv);
    localparam logic [2:0] CMD_XOR = 3'(Xor);

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic [CW-1:0] n_lat;

    logic [10:0]   n_raw;
    logic [CW-1:0] n_words;
    logic          cmd_legal;
    logic          cmd_two_op;
    logic [IW-1:0] wr_idx;
    logic          last_word;
    logic [W-1:0]  ins_a;
    logic [W-1:0]  ins_b;
    logic [W-1:0]  fin_a;
    logic [W-1:0]  fin_b;

`ifdef OPERAND_ASSEMBLER_MASK_EN
    logic [9:0]    poly_len_q;
    logic [9:0]    mask_len;
    logic [W-1:0]  keep;
`endif

    // Handshake: nothing is taken while an operand is held or during a flush.
    always_comb begin
        word_ready = (state != HOLD) && !flush;
    end

    // Words needed for the current field degree: ceil(m/Data), clamped to 1..MaxWords.
    always_comb begin
        n_raw = (11'(Polynomial_Length) + 11'(Data - 1)) / 11'(Data);
        if (n_raw == 11'd0) begin
            n_words = CW'(1);
        end else if (n_raw > 11'(MaxWords)) begin
            n_words = CW'(MaxWords);
        end else begin
            n_words = CW'(n_raw);
        end
    end

    // Op-code classification of the incoming command.
    always_comb begin
        cmd_legal  = (command == CMD_MUL) || (command == CMD_SQR) ||
                     (command == CMD_INV) || (command == CMD_XOR);
        cmd_two_op = (command == CMD_MUL) || (command == CMD_XOR);
    end

    // Merge the incoming word into the operand image; a first word starts from zero.
    always_comb begin
        wr_idx    = (state == IDLE) ? '0 : idx;
        last_word = (state == IDLE) ? (n_words == CW'(1))
                                    : (CW'(idx) == (n_lat - CW'(1)));
        ins_a     = (state == IDLE) ? '0 : op_a;
        ins_b     = (state == IDLE) ? '0 : op_b;
        for (int w = 0; w < MaxWords; w++) begin
            if (wr_idx == IW'(w)) begin
                ins_a[w*Data +: Data] = word_a;
                if (cmd_two_op) begin
                    ins_b[w*Data +: Data] = word_b;
                end
            end
        end
    end

`ifdef OPERAND_ASSEMBLER_MASK_EN
    // Keep only bits below m; a shift by >= W yields 0, so the minus one gives all ones.
    always_comb begin
        mask_len = (state == IDLE) ? Polynomial_Length : poly_len_q;
        keep     = (W'(1) << mask_len) - W'(1);
        fin_a    = last_word ? (ins_a & keep) : ins_a;
        fin_b    = last_word ? (ins_b & keep) : ins_b;
    end
`else
    // Words pass through as received.
    always_comb begin
        fin_a = ins_a;
        fin_b = ins_b;
    end
`endif

    // Sequencer: flush beats everything, then per-state word handling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            n_lat    <= CW'(1);
            op_a     <= '0;
            op_b     <= '0;
            op_cmd   <= 3'd0;
            op_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            if (flush) begin
                state    <= IDLE;
                idx      <= '0;
                op_a     <= '0;
                op_b     <= '0;
                op_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (word_valid) begin
                            if (cmd_legal) begin
                                op_a   <= fin_a;
                                op_b   <= fin_b;
                                op_cmd <= command;
                                n_lat  <= n_words;
                                if (n_words == CW'(1)) begin
                                    state    <= HOLD;
                                    op_valid <= 1'b1;
                                    idx      <= '0;
                                end else begin
                                    state <= COLLECT;
                                    idx   <= IW'(1);
                                end
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    COLLECT: begin
                        if (word_valid) begin
                            if (command == op_cmd) begin
                                op_a <= fin_a;
                                op_b <= fin_b;
                                if (last_word) begin
                                    state    <= HOLD;
                                    op_valid <= 1'b1;
                                    idx      <= '0;
                                end else begin
                                    idx <= idx + IW'(1);
                                end
                            end else begin
                                // A stray command kills the partial operand; the word is not reused.
                                op_a  <= '0;
                                op_b  <= '0;
                                err   <= 1'b1;
                                state <= IDLE;
                                idx   <= '0;
                            end
                        end
                    end
                    HOLD: begin
                        if (op_ready) begin
                            state    <= IDLE;
                            op_valid <= 1'b0;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        idx      <= '0;
                        op_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef OPERAND_ASSEMBLER_MASK_EN
    // Degree captured with the first word so later changes cannot reshape the operand.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            poly_len_q <= 10'd0;
        end else if (!flush && (state == IDLE) && word_valid && cmd_legal) begin
            poly_len_q <= Polynomial_Length;
        end
    end
`endif

endmodule

// File: tb/tb_operand_assembler.sv
// Testbench for operand_assembler: table vectors, directed corner sequences
// and randomized operations against a word-concatenation reference model.
module tb_operand_assembler;

    localparam int D = 256;
    localparam int W = 768;

    logic           clk;
    logic           rst;
    logic [D-1:0]   word_a;
    logic [D-1:0]   word_b;
    logic           word_valid;
    logic           word_ready;
    logic [2:0]     command;
    logic           flush;
    logic [9:0]     Polynomial_Length;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [2:0]     op_cmd;
    logic           op_valid;
    logic           op_ready;
    logic           err;

    int checks   = 0;
    int failures = 0;

    operand_assembler dut (
        .clk               (clk),
        .rst               (rst),
        .word_a            (word_a),
        .word_b            (word_b),
        .word_valid        (word_valid),
        .word_ready        (word_ready),
        .command           (command),
        .flush             (flush),
        .Polynomial_Length (Polynomial_Length),
        .op_a              (op_a),
        .op_b              (op_b),
        .op_cmd            (op_cmd),
        .op_valid          (op_valid),
        .op_ready          (op_ready),
        .err               (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0]   m;
        logic [2:0]   cmd;
        logic [1:0]   nw;
        logic [W-1:0] a_words;
        logic [W-1:0] b_words;
        logic [W-1:0] exp_a;
        logic [W-1:0] exp_b;
        logic [2:0]   exp_cmd;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic logic [D-1:0] rnd256();
        logic [D-1:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [W-1:0] low_bits(input int m);
        logic [W-1:0] one;
        one = 1;
        if (m >= W) return {W{1'b1}};
        return (one << m) - one;
    endfunction

    task automatic put_word(input logic [D-1:0] a, input logic [D-1:0] b, input logic [2:0] c);
        int n;
        n = 0;
        word_valid = 1'b1;
        word_a     = a;
        word_b     = b;
        command    = c;
        while (!word_ready && n < 20) begin
            tick();
            n++;
        end
        if (!word_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout word_ready got=0 want=1");
        end
        tick();
        word_valid = 1'b0;
    endtask

    task automatic take_op(input string name, input logic [W-1:0] ea, input logic [W-1:0] eb,
                           input logic [2:0] ec, input int stall);
        chk({name, "_valid"}, W'(op_valid), W'(1));
        for (int k = 0; k < stall; k++) begin
            chk({name, "_hold_ready"}, W'(word_ready), W'(0));
            chk({name, "_hold_a"}, op_a, ea);
            tick();
        end
        op_ready = 1'b1;
        chk({name, "_a"}, op_a, ea);
        chk({name, "_b"}, op_b, eb);
        chk({name, "_cmd"}, W'(op_cmd), W'(ec));
        tick();
        op_ready = 1'b0;
        chk({name, "_valid_drop"}, W'(op_valid), W'(0));
    endtask

    initial begin
        logic [D-1:0] ones;
        logic [D-1:0] a;
        logic [D-1:0] b;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic [2:0]   c;
        int           m;
        int           n;

        ones = {D{1'b1}};

        vecs[0] = '{m: 10'd163, cmd: 3'd1, nw: 2'd1,
                    a_words: W'(16'h1234), b_words: W'(16'hABCD),
                    exp_a: W'(16'h1234), exp_b: W'(16'hABCD), exp_cmd: 3'd1};
        vecs[1] = '{m: 10'd233, cmd: 3'd2, nw: 2'd1,
                    a_words: W'(ones), b_words: W'(ones),
`ifdef OPERAND_ASSEMBLER_MASK_EN
                    exp_a: low_bits(233),
`else
                    exp_a: W'(ones),
`endif
                    exp_b: '0, exp_cmd: 3'd2};
        vecs[2] = '{m: 10'd0, cmd: 3'd4, nw: 2'd1,
                    a_words: W'(8'h55), b_words: W'(8'h66),
`ifdef OPERAND_ASSEMBLER_MASK_EN
                    exp_a: '0, exp_b: '0,
`else
                    exp_a: W'(8'h55), exp_b: W'(8'h66),
`endif
                    exp_cmd: 3'd4};
        vecs[3] = '{m: 10'd512, cmd: 3'd1, nw: 2'd2,
                    a_words: {W'(8) << D} | W'(7), b_words: {W'(10) << D} | W'(9),
                    exp_a: {W'(8) << D} | W'(7), exp_b: {W'(10) << D} | W'(9),
                    exp_cmd: 3'd1};
        vecs[4] = '{m: 10'd1023, cmd: 3'd3, nw: 2'd3,
                    a_words: (W'(3) << (2*D)) | (W'(2) << D) | W'(1),
                    b_words: (W'(7) << (2*D)) | (W'(6) << D) | W'(5),
                    exp_a: (W'(3) << (2*D)) | (W'(2) << D) | W'(1),
                    exp_b: '0, exp_cmd: 3'd3};
        vecs[5] = '{m: 10'd257, cmd: 3'd4, nw: 2'd2,
                    a_words: (W'(ones) << D) | W'(ones),
                    b_words: (W'(3) << D) | W'(ones),
`ifdef OPERAND_ASSEMBLER_MASK_EN
                    exp_a: low_bits(257), exp_b: low_bits(257),
`else
                    exp_a: (W'(ones) << D) | W'(ones), exp_b: (W'(3) << D) | W'(ones),
`endif
                    exp_cmd: 3'd4};

        rst = 1'b1;
        word_a = '0;
        word_b = '0;
        word_valid = 1'b0;
        command = 3'd0;
        flush = 1'b0;
        Polynomial_Length = 10'd163;
        op_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // reset state
        chk("rst_valid", W'(op_valid), W'(0));
        chk("rst_err", W'(err), W'(0));
        chk("rst_cmd", W'(op_cmd), W'(0));
        chk("rst_a", op_a, '0);
        chk("rst_b", op_b, '0);
        chk("rst_ready", W'(word_ready), W'(1));

        // table vectors
        for (int v = 0; v < 6; v++) begin
            Polynomial_Length = vecs[v].m;
            for (int i = 0; i < int'(vecs[v].nw); i++) begin
                put_word(vecs[v].a_words[i*D +: D], vecs[v].b_words[i*D +: D], vecs[v].cmd);
                if (i < int'(vecs[v].nw) - 1) chk($sformatf("vec%0d_early_valid", v), W'(op_valid), W'(0));
            end
            take_op($sformatf("vec%0d", v), vecs[v].exp_a, vecs[v].exp_b, vecs[v].exp_cmd, 0);
        end

        // three-word Xor held for five cycles
        Polynomial_Length = 10'd571;
        put_word(D'(1), D'(4), 3'd4);
        put_word(D'(2), D'(5), 3'd4);
        put_word(D'(3), D'(6), 3'd4);
        take_op("xor3_hold", (W'(3) << (2*D)) | (W'(2) << D) | W'(1),
                (W'(6) << (2*D)) | (W'(5) << D) | W'(4), 3'd4, 5);
        chk("xor3_ready_after", W'(word_ready), W'(1));

        // command change mid-operand
        Polynomial_Length = 10'd409;
        put_word(D'(11), D'(12), 3'd1);
        put_word(D'(13), D'(14), 3'd2);
        chk("mismatch_err", W'(err), W'(1));
        chk("mismatch_valid", W'(op_valid), W'(0));
        chk("mismatch_a_clr", op_a, '0);
        tick();
        chk("mismatch_err_pulse", W'(err), W'(0));
        chk("mismatch_valid2", W'(op_valid), W'(0));
        put_word(D'(21), D'(22), 3'd1);
        put_word(D'(23), D'(24), 3'd1);
        take_op("after_mismatch", (W'(23) << D) | W'(21), (W'(24) << D) | W'(22), 3'd1, 0);

        // illegal command in IDLE
        put_word(D'(99), D'(98), 3'd5);
        chk("illegal_err", W'(err), W'(1));
        chk("illegal_ready", W'(word_ready), W'(1));
        chk("illegal_valid", W'(op_valid), W'(0));
        tick();
        chk("illegal_err_pulse", W'(err), W'(0));

        // flush with a valid third word
        Polynomial_Length = 10'd571;
        put_word(D'(31), D'(32), 3'd3);
        put_word(D'(33), D'(34), 3'd3);
        word_valid = 1'b1;
        word_a = D'(35);
        word_b = D'(36);
        command = 3'd3;
        flush = 1'b1;
        #1;
        chk("flush_ready", W'(word_ready), W'(0));
        tick();
        flush = 1'b0;
        word_valid = 1'b0;
        chk("flush_valid", W'(op_valid), W'(0));
        chk("flush_err", W'(err), W'(0));
        chk("flush_a_clr", op_a, '0);
        tick();
        chk("flush_valid2", W'(op_valid), W'(0));
        put_word(D'(41), D'(42), 3'd3);
        put_word(D'(43), D'(44), 3'd3);
        put_word(D'(45), D'(46), 3'd3);
        take_op("after_flush", (W'(45) << (2*D)) | (W'(43) << D) | W'(41), '0, 3'd3, 1);

        // randomized operations against the concatenation model
        for (int t = 0; t < 40; t++) begin
            m = $urandom_range(0, 1023);
            c = 3'($urandom_range(1, 4));
            n = (m == 0) ? 1 : (m + D - 1) / D;
            if (n > 3) n = 3;
            ea = '0;
            eb = '0;
            Polynomial_Length = 10'(m);
            for (int i = 0; i < n; i++) begin
                a = rnd256();
                b = rnd256();
                for (int g = $urandom_range(0, 2); g > 0; g--) tick();
                put_word(a, b, c);
                if (i == 0) Polynomial_Length = 10'($urandom);
                ea = ea | (W'(a) << (i*D));
                if (c == 3'd1 || c == 3'd4) eb = eb | (W'(b) << (i*D));
                if (i < n - 1) chk("rnd_early_valid", W'(op_valid), W'(0));
            end
`ifdef OPERAND_ASSEMBLER_MASK_EN
            ea = ea & low_bits(m);
            eb = eb & low_bits(m);
`endif
            take_op("rnd", ea, eb, c, $urandom_range(0, 3));
        end

        // asynchronous reset mid-COLLECT
        Polynomial_Length = 10'd571;
        put_word(D'(51), D'(52), 3'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_col_cmd", W'(op_cmd), W'(0));
        chk("arst_col_a", op_a, '0);
        chk("arst_col_b", op_b, '0);
        chk("arst_col_valid", W'(op_valid), W'(0));
        #1 rst = 1'b0;
        tick();
        chk("arst_col_ready", W'(word_ready), W'(1));

        // asynchronous reset in HOLD
        Polynomial_Length = 10'd100;
        put_word(D'(61), D'(62), 3'd4);
        chk("arst_hold_pre", W'(op_valid), W'(1));
        #2 rst = 1'b1;
        #1;
        chk("arst_hold_valid", W'(op_valid), W'(0));
        chk("arst_hold_a", op_a, '0);
        chk("arst_hold_b", op_b, '0);
        chk("arst_hold_err", W'(err), W'(0));
        #1 rst = 1'b0;
        tick();
        chk("arst_hold_ready", W'(word_ready), W'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/operand_assembler.md
Name: operand_assembler

Overview:
- Downstream neighbour of the per-command operand register stage.
- Consumes the 256-bit A/B word stream that stage emits during a FIFO dump (1–3 words per operation).
- Reassembles the words into full-width operands of up to 768 bits, tagged with the field-operation code.
- Presents the assembled operand to the GF(2^m) arithmetic units through a valid/ready handshake.

Parameters:
- Data, 256, width of one transfer word in bits.
- MaxWords, 3, maximum words per operand; assembled width is Data*MaxWords.
- Mul, 1, op code: multiply (two operands).
- Sqr, 2, op code: square (operand A only).
- Inv, 3, op code: inverse (operand A only).
- Xor, 4, op code: add/XOR (two operands).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- word_a  input  Data  incoming A word (Data_Out_A of the upstream stage).
- word_b  input  Data  incoming B word (Data_Out_B of the upstream stage).
- word_valid  input  1  word_a/word_b/command are valid this cycle.
- word_ready  output  1  block can accept a word this cycle.
- command  input  3  op code that accompanies the word.
- flush  input  1  synchronous abort; discards any partial or held operand.
- Polynomial_Length  input  10  field degree m (e.g. 163, 233, 283, 409, 571).
- op_a  output  Data*MaxWords  assembled operand A.
- op_b  output  Data*MaxWords  assembled operand B.
- op_cmd  output  3  op code of the assembled operand.
- op_valid  output  1  assembled operand is available.
- op_ready  input  1  consumer accepts the operand.
- err  output  1  one-cycle pulse on a protocol error.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state IDLE; op_a, op_b, op_cmd, op_valid, err all 0; internal word index 0.
- Word count: N = ceil(Polynomial_Length/Data), clamped to 1..MaxWords; Polynomial_Length=0 gives N=1.
  - N and command are latched when the first word of an operand is accepted.
  - Later changes to Polynomial_Length do not affect the operand in progress.
- Accept rule: a word is taken when word_valid && word_ready. word_ready = (state != HOLD) && !flush.
- States:
  - IDLE → accept with a legal command (1..4): clear op_a/op_b; write word i=0 into bits [0 +: Data]; latch op_cmd; go to COLLECT if N>1, else HOLD.
  - IDLE → accept with an illegal command (0, 5–7): word dropped, err pulses, stay in IDLE.
  - COLLECT → accept with command == latched op_cmd: write word i into bits [i*Data +: Data]; i++; go to HOLD when i reaches N-1.
  - COLLECT → accept with a different command: discard the partial operand (op_a/op_b cleared), drop the word, err pulses, go to IDLE. The word is not restarted as a new operand.
  - HOLD → op_valid=1; op_a/op_b/op_cmd stable until op_ready. On op_valid && op_ready go to IDLE; op_valid falls next cycle.
- Unfilled words: upper words (index ≥ N) read as zero.
- Single-operand ops: for Sqr and Inv, word_b is ignored and op_b stays zero.
- Latency: op_valid rises on the clock edge that accepts the last word (registered; visible the following cycle).
- No same-cycle turnaround: a new word is not accepted in the cycle op_ready completes a handshake. Minimum issue interval is N+1 cycles.
- flush: takes priority over every other event.
  - Next state IDLE; op_valid=0; op_a/op_b cleared; no err.
  - A word presented in the same cycle is not accepted (word_ready low).
- Reset mid-operation: all state is lost immediately; there is no partial-operand output.
- Index width: the internal word index is 2 bits and never exceeds MaxWords-1.

Optional Feature:
- Macro: OPERAND_ASSEMBLER_MASK_EN.
- Defined: when entering HOLD, bits at positions ≥ Polynomial_Length (as latched) in op_a and op_b are forced to 0, so op_a/op_b hold only the m significant bits. Latency is unchanged (mask applied in the same registered write).
- Undefined: words pass through unmasked; bits above m in the last word appear as received.

Test Plan:
- m=163, command=Mul, one word A=0x1234, B=0xABCD, op_ready=1 → op_valid 1 cycle after accept; op_a[255:0]=0x1234, op_b[255:0]=0xABCD, upper 512 bits 0; op_cmd=1.
- m=571, Xor, three words A=1,2,3 on consecutive cycles, op_ready=0 for 5 cycles → op_a = 3<<512 | 2<<256 | 1; word_ready low and op_a stable through HOLD; released on op_ready.
- m=409, Mul, word 0 then word 1 carrying command=Sqr → err pulses once, back to IDLE, op_valid never asserted; next full Mul completes normally.
- m=233, Sqr, word_a=all ones, word_b=all ones → op_b=0. With OPERAND_ASSEMBLER_MASK_EN: op_a=2^233-1. Without it: op_a[255:0] all ones.
- m=571, Inv, flush asserted after word 1 together with a valid word 2 → word 2 not accepted, op_valid stays 0, no err; a fresh 3-word Inv then assembles correctly.
- rst asserted asynchronously mid-COLLECT and while in HOLD → op_valid, err, op_cmd, op_a, op_b all 0 immediately; word_ready 1 after release.
